// File: rtl/idex_operand_stage_if.sv
// Decode-to-execute bundle: decoded operands/control, hazard controls, MEM/WB forwarding
// sources, and the ALU-facing results of the ID/EX operand stage.
interface idex_operand_stage_if #(
  parameter int XLEN = 32
);
  logic            d_valid;
  logic [XLEN-1:0] d_rd1;
  logic [XLEN-1:0] d_rd2;
  logic [XLEN-1:0] d_signimm;
  logic [4:0]      d_rs;
  logic [4:0]      d_rt;
  logic [4:0]      d_rd;
  logic [2:0]      d_alucont;
  logic            d_alusrc;
  logic            d_regdst;
  logic            d_regwrite;
  logic            d_memtoreg;
  logic            d_memwrite;
  logic            stall;
  logic            flush;
  logic            m_regwrite;
  logic [4:0]      m_writereg;
  logic [XLEN-1:0] m_aluout;
  logic            w_regwrite;
  logic [4:0]      w_writereg;
  logic [XLEN-1:0] w_result;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic [XLEN-1:0] writedata;
  logic [2:0]      alucont;
  logic [4:0]      writereg;
  logic            e_valid;
  logic            e_regwrite;
  logic            e_memtoreg;
  logic            e_memwrite;
  logic            lu_stall;

  modport master (
    output d_valid, d_rd1, d_rd2, d_signimm, d_rs, d_rt, d_rd, d_alucont,
           d_alusrc, d_regdst, d_regwrite, d_memtoreg, d_memwrite,
           stall, flush, m_regwrite, m_writereg, m_aluout,
           w_regwrite, w_writereg, w_result,
    input  srca, srcb, writedata, alucont, writereg,
           e_valid, e_regwrite, e_memtoreg, e_memwrite, lu_stall
  );

  modport slave (
    input  d_valid, d_rd1, d_rd2, d_signimm, d_rs, d_rt, d_rd, d_alucont,
           d_alusrc, d_regdst, d_regwrite, d_memtoreg, d_memwrite,
           stall, flush, m_regwrite, m_writereg, m_aluout,
           w_regwrite, w_writereg, w_result,
    output srca, srcb, writedata, alucont, writereg,
           e_valid, e_regwrite, e_memtoreg, e_memwrite, lu_stall
  );
endinterface

// File: rtl/idex_operand_stage.sv
// ID/EX register with MEM>WB operand forwarding; one cycle from d_* to E fields, outputs combinational.
// Flush (bubble) beats stall (hold); lu_stall requests a decode stall, no self-inserted bubbles.
module idex_operand_stage #(
  parameter int XLEN = 32
) (
  input logic                  clk,
  input logic                  reset,
  idex_operand_stage_if.slave  bus
);
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] signimm;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [2:0]      alucont;
    logic            alusrc;
    logic            regdst;
    logic            regwrite;
    logic            memtoreg;
    logic            memwrite;
  } ex_t;

  ex_t ex_q, ex_d;

  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d         = '0;
      ex_d.alucont = 3'b010;
    end else if (!bus.stall) begin
      ex_d.valid    = bus.d_valid;
      ex_d.rd1      = bus.d_rd1;
      ex_d.rd2      = bus.d_rd2;
      ex_d.signimm  = bus.d_signimm;
      ex_d.rs       = bus.d_rs;
      ex_d.rt       = bus.d_rt;
      ex_d.rd       = bus.d_rd;
      ex_d.alucont  = bus.d_alucont;
      ex_d.alusrc   = bus.d_alusrc;
      ex_d.regdst   = bus.d_regdst;
      ex_d.regwrite = bus.d_regwrite;
      ex_d.memtoreg = bus.d_memtoreg;
      ex_d.memwrite = bus.d_memwrite;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  // r0 is hardwired zero, so a write to it must never be forwarded
  function automatic logic [XLEN-1:0] fwd(
    input logic [4:0]      s,
    input logic [XLEN-1:0] regv,
    input logic            mw,
    input logic [4:0]      mreg,
    input logic [XLEN-1:0] mval,
    input logic            ww,
    input logic [4:0]      wreg,
    input logic [XLEN-1:0] wval
  );
    if (s != 5'd0 && mw && mreg == s)      return mval;
    else if (s != 5'd0 && ww && wreg == s) return wval;
    else                                   return regv;
  endfunction

  logic [XLEN-1:0] fwd_rs, fwd_rt;
  logic [4:0]      writereg;
  logic            e_memtoreg;

  always_comb begin
    fwd_rs = fwd(ex_q.rs, ex_q.rd1, bus.m_regwrite, bus.m_writereg, bus.m_aluout,
                 bus.w_regwrite, bus.w_writereg, bus.w_result);
    fwd_rt = fwd(ex_q.rt, ex_q.rd2, bus.m_regwrite, bus.m_writereg, bus.m_aluout,
                 bus.w_regwrite, bus.w_writereg, bus.w_result);
  end

  assign writereg   = ex_q.regdst ? ex_q.rd : ex_q.rt;
  assign e_memtoreg = ex_q.memtoreg & ex_q.valid;

  assign bus.srca       = fwd_rs;
  assign bus.writedata  = fwd_rt;
  assign bus.srcb       = ex_q.alusrc ? ex_q.signimm : fwd_rt;
  assign bus.alucont    = ex_q.alucont;
  assign bus.writereg   = writereg;
  assign bus.e_valid    = ex_q.valid;
  assign bus.e_regwrite = ex_q.regwrite & ex_q.valid;
  assign bus.e_memtoreg = e_memtoreg;
  assign bus.e_memwrite = ex_q.memwrite & ex_q.valid;
  assign bus.lu_stall   = e_memtoreg & (writereg != 5'd0) &
                          ((writereg == bus.d_rs) | (writereg == bus.d_rt)) & bus.d_valid;
endmodule

// File: tb/tb_idex_operand_stage.sv
// Directed bench for idex_operand_stage: instruction-slot model checked every cycle plus literal expectations.
module tb_idex_operand_stage;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  idex_operand_stage_if #(.XLEN(32)) bus ();
  idex_operand_stage #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // What instruction currently occupies the execute slot
  typedef struct {
    bit        valid;
    bit [31:0] rd1, rd2, imm;
    bit [4:0]  rs, rt, rd;
    bit [2:0]  op;
    bit        alusrc, regdst, regwrite, memtoreg, memwrite;
  } slot_t;

  slot_t slot = '{default: 0};

  always @(posedge clk or negedge reset) begin
    if (!reset) slot = '{default: 0};
    else if (bus.flush) begin
      slot    = '{default: 0};
      slot.op = 3'b010;
    end else if (!bus.stall) begin
      slot = '{valid: bus.d_valid, rd1: bus.d_rd1, rd2: bus.d_rd2, imm: bus.d_signimm,
               rs: bus.d_rs, rt: bus.d_rt, rd: bus.d_rd, op: bus.d_alucont,
               alusrc: bus.d_alusrc, regdst: bus.d_regdst, regwrite: bus.d_regwrite,
               memtoreg: bus.d_memtoreg, memwrite: bus.d_memwrite};
    end
  end

  // Newest in-flight producer of a register wins; register 0 always reads its file value
  function automatic bit [31:0] operand(input bit [4:0] r, input bit [31:0] file_val);
    if (r == 0) return file_val;
    if (bus.m_regwrite && bus.m_writereg == r) return bus.m_aluout;
    if (bus.w_regwrite && bus.w_writereg == r) return bus.w_result;
    return file_val;
  endfunction

  always @(negedge clk) begin
    bit [31:0] a, t;
    bit [4:0]  dst;
    bit        is_load;
    a       = operand(slot.rs, slot.rd1);
    t       = operand(slot.rt, slot.rd2);
    dst     = slot.regdst ? slot.rd : slot.rt;
    is_load = slot.valid && slot.memtoreg;
    chk("m_srca", bus.srca, a);
    chk("m_srcb", bus.srcb, slot.alusrc ? slot.imm : t);
    chk("m_writedata", bus.writedata, t);
    chk("m_alucont", 32'(bus.alucont), 32'(slot.op));
    chk("m_writereg", 32'(bus.writereg), 32'(dst));
    chk("m_e_valid", 32'(bus.e_valid), 32'(slot.valid));
    chk("m_e_regwrite", 32'(bus.e_regwrite), 32'(slot.valid && slot.regwrite));
    chk("m_e_memtoreg", 32'(bus.e_memtoreg), 32'(is_load));
    chk("m_e_memwrite", 32'(bus.e_memwrite), 32'(slot.valid && slot.memwrite));
    chk("m_lu_stall", 32'(bus.lu_stall),
        32'(is_load && dst != 0 && bus.d_valid && (dst == bus.d_rs || dst == bus.d_rt)));
  end

  task automatic clr_d();
    bus.d_valid = 0; bus.d_rd1 = 0; bus.d_rd2 = 0; bus.d_signimm = 0;
    bus.d_rs = 0; bus.d_rt = 0; bus.d_rd = 0; bus.d_alucont = 3'b010;
    bus.d_alusrc = 0; bus.d_regdst = 0; bus.d_regwrite = 0;
    bus.d_memtoreg = 0; bus.d_memwrite = 0;
  endtask

  task automatic clr_fwd();
    bus.m_regwrite = 0; bus.m_writereg = 0; bus.m_aluout = 0;
    bus.w_regwrite = 0; bus.w_writereg = 0; bus.w_result = 0;
  endtask

  // Advance to just after the next rising edge, where inputs are changed
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_d();
    clr_fwd();
    bus.stall = 0;
    bus.flush = 0;
    #1 reset = 0;
    #1;
    chk("rst_srca", bus.srca, 32'h0);
    chk("rst_alucont", 32'(bus.alucont), 32'h0);
    chk("rst_e_valid", 32'(bus.e_valid), 32'h0);
    edge1();
    reset = 1;

    // add r3 = r1 + r2
    bus.d_valid = 1; bus.d_rd1 = 5; bus.d_rd2 = 7; bus.d_rs = 1; bus.d_rt = 2;
    bus.d_rd = 3; bus.d_regdst = 1; bus.d_regwrite = 1; bus.d_alucont = 3'b010;
    edge1();
    #1;
    chk("add_srca", bus.srca, 32'd5);
    chk("add_srcb", bus.srcb, 32'd7);
    chk("add_alucont", 32'(bus.alucont), 32'h2);
    chk("add_e_valid", 32'(bus.e_valid), 32'h1);
    chk("add_writereg", 32'(bus.writereg), 32'd3);

    // forwarding priority on rs=3
    bus.d_rs = 3; bus.d_rd1 = 32'hAA; bus.d_rt = 2; bus.d_rd2 = 32'hBB;
    edge1();
    bus.m_regwrite = 1; bus.m_writereg = 3; bus.m_aluout = 32'h11;
    bus.w_regwrite = 1; bus.w_writereg = 3; bus.w_result = 32'h22;
    #1 chk("fwd_mem", bus.srca, 32'h11);
    bus.m_regwrite = 0;
    #1 chk("fwd_wb", bus.srca, 32'h22);
    bus.m_regwrite = 1;
    bus.m_writereg = 0; bus.w_writereg = 0;
    bus.d_rs = 0; bus.d_rd1 = 32'h55;
    edge1();
    #1 chk("fwd_r0", bus.srca, 32'h55);

    // immediate operand and forwarded store data
    clr_fwd();
    bus.d_alusrc = 1; bus.d_signimm = 32'hFFFF_FFFC; bus.d_rt = 2; bus.d_rd2 = 32'h10;
    bus.d_memwrite = 1; bus.d_regwrite = 0;
    edge1();
    bus.w_regwrite = 1; bus.w_writereg = 2; bus.w_result = 32'h99;
    #1;
    chk("imm_srcb", bus.srcb, 32'hFFFF_FFFC);
    chk("st_writedata", bus.writedata, 32'h99);
    chk("st_e_memwrite", 32'(bus.e_memwrite), 32'h1);

    // lw r4: load-use detection
    clr_fwd();
    clr_d();
    bus.d_valid = 1; bus.d_memtoreg = 1; bus.d_regwrite = 1; bus.d_alusrc = 1;
    bus.d_rs = 1; bus.d_rt = 4;
    edge1();
    bus.d_valid = 1; bus.d_memtoreg = 0; bus.d_rs = 1; bus.d_rt = 4;
    #1;
    chk("lu_rt", 32'(bus.lu_stall), 32'h1);
    chk("lu_e_memtoreg", 32'(bus.e_memtoreg), 32'h1);
    bus.d_rs = 4; bus.d_rt = 5;
    #1 chk("lu_rs", 32'(bus.lu_stall), 32'h1);
    bus.d_rs = 6;
    #1 chk("lu_nomatch", 32'(bus.lu_stall), 32'h0);
    bus.d_memtoreg = 1; bus.d_rt = 0; bus.d_rs = 1;
    edge1();
    bus.d_memtoreg = 0; bus.d_rs = 0; bus.d_rt = 0;
    #1 chk("lu_r0", 32'(bus.lu_stall), 32'h0);

    // stall holds a sub instruction for 3 edges while decode changes
    clr_d();
    bus.d_valid = 1; bus.d_rs = 7; bus.d_rd1 = 32'h123; bus.d_rt = 8; bus.d_rd2 = 32'h456;
    bus.d_alucont = 3'b110; bus.d_regwrite = 1;
    edge1();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      bus.d_rd1 = $urandom; bus.d_rd2 = $urandom; bus.d_rs = 5'($urandom_range(1, 31));
      bus.d_alucont = 3'b111; bus.d_valid = 0;
      edge1();
      chk("stall_srca", bus.srca, 32'h123);
      chk("stall_srcb", bus.srcb, 32'h456);
      chk("stall_alucont", 32'(bus.alucont), 32'h6);
    end

    // flush wins over stall
    bus.flush = 1;
    edge1();
    bus.flush = 0; bus.stall = 0;
    chk("flush_e_valid", 32'(bus.e_valid), 32'h0);
    chk("flush_e_regwrite", 32'(bus.e_regwrite), 32'h0);
    chk("flush_alucont", 32'(bus.alucont), 32'h2);
    chk("flush_srca", bus.srca, 32'h0);

    // asynchronous reset mid-cycle, then first capture
    clr_d();
    bus.d_valid = 1; bus.d_rs = 9; bus.d_rd1 = 32'hDEAD; bus.d_memtoreg = 1; bus.d_rt = 9;
    bus.d_alucont = 3'b001; bus.d_regwrite = 1;
    edge1();
    reset = 0;
    #1;
    chk("arst_srca", bus.srca, 32'h0);
    chk("arst_alucont", 32'(bus.alucont), 32'h0);
    chk("arst_e_valid", 32'(bus.e_valid), 32'h0);
    chk("arst_lu_stall", 32'(bus.lu_stall), 32'h0);
    reset = 1;
    bus.d_memtoreg = 0; bus.d_rd1 = 32'hBEEF;
    edge1();
    chk("post_rst_srca", bus.srca, 32'hBEEF);
    chk("post_rst_alucont", 32'(bus.alucont), 32'h1);
    chk("post_rst_e_valid", 32'(bus.e_valid), 32'h1);

    clr_d();
    repeat (3) @(posedge clk);
    #6;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
